iiitb_tlc_gen: RTL and testbench
================================

Name: iiitb_tlc_gen

Overview:
Parametrised highway/farm-road traffic light controller, the successor of the fixed two-road controller.
- Generates its own 1 s tick from `clk` with a configurable divider.
- Adds a minimum highway-green time, a latched farm-road vehicle request, a farm-green extension while vehicles remain, and an optional all-red clearance interval.
- Sits at the top of the TLC design, driving the lamp drivers directly.

Parameters:
CLK_DIV, 4, clk cycles per 1 s tick (50000000 on FPGA; 4 for simulation); >=1
CNT_W, 8, width of the per-state seconds counter; must hold T_FMAX
T_HMIN, 5, minimum highway green, seconds; >=1
T_YEL, 3, yellow duration on either road, seconds; >=1
T_ALLRED, 1, all-red clearance, seconds; 0 = clearance states skipped
T_FGRN, 10, base farm green, seconds; >=1
T_FMAX, 20, maximum farm green including extension, seconds; >=T_FGRN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
C  in  1  farm-road vehicle sensor, synchronous to clk
light_highway  out  3  highway lamp: 001 green, 010 yellow, 100 red
light_farm  out  3  farm lamp, same encoding
state_o  out  3  current FSM state code
tick_o  out  1  one-cycle 1 s tick pulse
req_o  out  1  latched farm request

Behaviour:
Reset and clocking
- One clock, `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=HGRE, prescaler=0, sec_cnt=0, req=0, tick_o=0. Outputs light_highway=001, light_farm=100, state_o=0.
- Lamps and state_o are decoded combinationally from the state register, so they are valid immediately on reset.

Tick and seconds counter
- Prescaler counts 0..CLK_DIV-1 and is cleared on every state change.
- tick_o=1 in the cycle where prescaler==CLK_DIV-1.
- sec_cnt is cleared on state change and increments on each tick_o, saturating at 2^CNT_W-1.
- "Second n completes" means the tick edge on which sec_cnt goes from n-1 to n.
- Consequence: a state of T seconds lasts exactly T*CLK_DIV cycles.

States (code: highway/farm lamps)
- HGRE (0: 001/100)
- HYEL (1: 010/100)
- ARED1 (2: 100/100)
- FGRE (3: 100/001)
- FYEL (4: 100/010)
- ARED2 (5: 100/100)
- Codes 6/7 are illegal: lamps 100/100, next state HGRE.

Request latch
- req is held 0 while in FGRE.
- In every other state, req is set on any cycle with C=1.
- req stays set until the next FGRE entry. req_o = req.

Transitions
- HGRE -> HYEL:
  - on the edge completing second T_HMIN, if req|C; or
  - on any later cycle where req|C.
  - With no request, HGRE holds indefinitely.
- HYEL -> ARED1 when second T_YEL completes. If T_ALLRED=0, HYEL -> FGRE directly.
- ARED1 -> FGRE when second T_ALLRED completes.
- FGRE -> FYEL on the tick edge completing second n, where:
  - n=T_FGRN and C=0 at that edge; or
  - T_FGRN<n<T_FMAX and C=0 at that edge; or
  - n=T_FMAX, regardless of C.
- FYEL -> ARED2 when second T_YEL completes. If T_ALLRED=0, FYEL -> HGRE directly.
- ARED2 -> HGRE when second T_ALLRED completes.

Boundary rules
- Simultaneous C and a transition edge: C updates req per the current (pre-transition) state. Exception: on the edge entering FGRE, req clears.
- Reset mid-state: all state, req and counters return to reset values immediately. No partial sequence resumes.
- Highway green and farm green are never decoded simultaneously in any state, legal or illegal.

Test Plan:
- Reset, C=0 for 200 cycles -> state_o=0 throughout, lamps 001/100, req_o=0, tick_o every 4th cycle.
- Release reset, pulse C for 1 cycle at cycle 2, C=0 afterwards -> req_o=1 from cycle 3. State durations in cycles: HGRE 20, HYEL 12, ARED1 4, FGRE 40, FYEL 12, ARED2 4. Then HGRE with req_o=0.
- C held high from reset:
  - HGRE 20 cycles, then FGRE extends to 80 cycles (T_FMAX).
  - req re-latches in FYEL, so the next HGRE lasts exactly 20 cycles before HYEL.
- C high entering FGRE, dropped at FGRE cycle 56 (mid second 15) -> FGRE exits on the edge completing second 15, i.e. FGRE lasts 60 cycles.
- Assert rst at FGRE cycle 10 -> same cycle: lamps 001/100, state_o=0, req_o=0. After release, the cycle restarts from HGRE with prescaler=0.
- Variant T_ALLRED=0, C pulse -> HYEL (12 cycles) goes straight to FGRE; FYEL goes straight to HGRE. state_o never shows 2 or 5.

Source files
------------

// File: rtl/iiitb_tlc_gen.sv
// Highway/farm-road traffic light controller with a built-in 1 s tick.
// It adds a minimum highway green, a latched farm request, a farm green
// extension while vehicles remain, and an optional all-red clearance.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   C             farm-road vehicle sensor (synchronous to clk)
//   light_highway highway lamp, 001 green / 010 yellow / 100 red
//   light_farm    farm lamp, same encoding
//   state_o       current FSM state code
//   tick_o        one-cycle pulse per second
//   req_o         latched farm request
module iiitb_tlc_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned T_HMIN   = 5,
    parameter int unsigned T_YEL    = 3,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_FGRN   = 10,
    parameter int unsigned T_FMAX   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       C,
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    output logic [2:0] state_o,
    output logic       tick_o,
    output logic       req_o
);

    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic        ALLRED_EN = (T_ALLRED != 0);
    localparam logic [CNT_W-1:0] SEC_MAX = '1;

    localparam logic [2:0] S_HGRE  = 3'd0;
    localparam logic [2:0] S_HYEL  = 3'd1;
    localparam logic [2:0] S_ARED1 = 3'd2;
    localparam logic [2:0] S_FGRE  = 3'd3;
    localparam logic [2:0] S_FYEL  = 3'd4;
    localparam logic [2:0] S_ARED2 = 3'd5;

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    logic [2:0]       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] sec_q, sec_d;
    logic             req_q, req_d;

    logic             tick;
    logic [CNT_W-1:0] sec_inc;
    logic             hmin_ok;
    logic             yel_done;
    logic             ared_done;
    logic             fmax_done;
    logic             fgrn_exit;
    logic             changed;

    // Seconds bookkeeping: sec_inc is the count that the current tick edge produces.
    assign tick    = (pre_q == PRE_W'(CLK_DIV - 1));
    assign sec_inc = (sec_q == SEC_MAX) ? sec_q : sec_q + CNT_W'(1);

    // "Second T completes" is the tick edge that moves the counter to T.
    assign yel_done  = tick && (sec_inc == CNT_W'(T_YEL));
    assign ared_done = tick && (sec_inc == CNT_W'(T_ALLRED));
    assign fmax_done = tick && (sec_inc == CNT_W'(T_FMAX));
    assign fgrn_exit = tick && !C && (sec_inc >= CNT_W'(T_FGRN));
    // Minimum highway green is met on its completing edge or any time after.
    assign hmin_ok   = (sec_q >= CNT_W'(T_HMIN)) ||
                       (tick && (sec_inc == CNT_W'(T_HMIN)));

    // Next-state, counter and request logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HGRE:  if ((req_q || C) && hmin_ok) state_d = S_HYEL;
            S_HYEL:  if (yel_done) state_d = ALLRED_EN ? S_ARED1 : S_FGRE;
            S_ARED1: if (ared_done) state_d = S_FGRE;
            S_FGRE:  if (fmax_done || fgrn_exit) state_d = S_FYEL;
            S_FYEL:  if (yel_done) state_d = ALLRED_EN ? S_ARED2 : S_HGRE;
            S_ARED2: if (ared_done) state_d = S_HGRE;
            default: state_d = S_HGRE;
        endcase

        changed = (state_d != state_q);
        pre_d   = (changed || tick) ? '0 : pre_q + PRE_W'(1);
        sec_d   = changed ? '0 : (tick ? sec_inc : sec_q);
        // Request is suppressed while in farm green and cleared on entry to it.
        req_d   = ((state_q == S_FGRE) || (state_d == S_FGRE)) ? 1'b0 : (req_q || C);
    end

    // State, prescaler, seconds counter and request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HGRE;
            pre_q   <= '0;
            sec_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            sec_q   <= sec_d;
            req_q   <= req_d;
        end
    end

    // Lamp decode; illegal codes fall back to all-red so both greens never coincide.
    always_comb begin
        light_highway = LAMP_R;
        light_farm    = LAMP_R;
        case (state_q)
            S_HGRE: light_highway = LAMP_G;
            S_HYEL: light_highway = LAMP_Y;
            S_FGRE: light_farm    = LAMP_G;
            S_FYEL: light_farm    = LAMP_Y;
            default: begin
                light_highway = LAMP_R;
                light_farm    = LAMP_R;
            end
        endcase
    end

    assign state_o = state_q;
    assign tick_o  = tick;
    assign req_o   = req_q;

endmodule

// File: tb/tb_iiitb_tlc_gen.sv
// Testbench for iiitb_tlc_gen: a default-parameter instance and a no-clearance
// instance share one sensor input and are both checked every cycle against a
// cycle-count reference model, plus phase-duration tables and directed resets.
module tb_iiitb_tlc_gen;

    localparam int DIV  = 4;
    localparam int HMIN = 5;
    localparam int YEL  = 3;
    localparam int ALR  = 1;
    localparam int FGRN = 10;
    localparam int FMAX = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       c   = 1'b0;
    logic [2:0] hw_a, fm_a, st_a, hw_b, fm_b, st_b;
    logic       tk_a, rq_a, tk_b, rq_b;

    iiitb_tlc_gen u_dut_a (
        .clk(clk), .rst(rst), .C(c),
        .light_highway(hw_a), .light_farm(fm_a), .state_o(st_a),
        .tick_o(tk_a), .req_o(rq_a)
    );

    iiitb_tlc_gen #(.T_ALLRED(0)) u_dut_b (
        .clk(clk), .rst(rst), .C(c),
        .light_highway(hw_b), .light_farm(fm_b), .state_o(st_b),
        .tick_o(tk_b), .req_o(rq_b)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: phase code, cycles already spent in the phase, latched request.
    int ms [2];
    int mk [2];
    bit mreq [2];

    typedef struct {
        int rst_first;
        int st;
        int c_from;
        int c_to;
        int len;
    } phase_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_hw(input int s);
        return (s == 0) ? 1 : (s == 1) ? 2 : 4;
    endfunction

    function automatic int exp_fm(input int s);
        return (s == 3) ? 1 : (s == 4) ? 2 : 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; mk[i] = 0; mreq[i] = 1'b0;
        end
    endtask

    // Advance one clock edge using the sensor value seen at that edge.
    task automatic model_step(input int i, input bit cv);
        int  k1, n, nxt, alr;
        bit  sec_done;
        alr      = (i == 0) ? ALR : 0;
        k1       = mk[i] + 1;
        sec_done = (k1 % DIV) == 0;
        n        = k1 / DIV;
        nxt      = ms[i];
        case (ms[i])
            0: if ((mreq[i] || cv) && k1 >= HMIN * DIV) nxt = 1;
            1: if (sec_done && n == YEL) nxt = (alr != 0) ? 2 : 3;
            2: if (sec_done && n == alr) nxt = 3;
            3: if (sec_done && (n == FMAX || (n >= FGRN && !cv))) nxt = 4;
            4: if (sec_done && n == YEL) nxt = (alr != 0) ? 5 : 0;
            default: if (sec_done && n == alr) nxt = 0;
        endcase
        if (ms[i] == 3 || nxt == 3) mreq[i] = 1'b0;
        else                        mreq[i] = mreq[i] | cv;
        mk[i] = (nxt != ms[i]) ? 0 : k1;
        ms[i] = nxt;
    endtask

    task automatic check_inst(input string tag, input int i, input logic [2:0] st,
                              input logic [2:0] hw, input logic [2:0] fm,
                              input logic tk, input logic rq);
        int et;
        et = (!rst && (mk[i] % DIV) == DIV - 1) ? 1 : 0;
        chk({tag, ".state"}, 32'(st), 32'(ms[i]));
        chk({tag, ".hw"},    32'(hw), 32'(exp_hw(ms[i])));
        chk({tag, ".farm"},  32'(fm), 32'(exp_fm(ms[i])));
        chk({tag, ".tick"},  32'(tk), 32'(et));
        chk({tag, ".req"},   32'(rq), 32'(mreq[i]));
    endtask

    task automatic check_both();
        check_inst("a", 0, st_a, hw_a, fm_a, tk_a, rq_a);
        check_inst("b", 1, st_b, hw_b, fm_b, tk_b, rq_b);
        chk("b.no_allred_state", 32'((st_b == 3'd2) || (st_b == 3'd5)), 32'd0);
    endtask

    // One clock: check at the falling edge, drive C, step the model.
    task automatic cyc(input bit cv);
        check_both();
        c = cv;
        model_step(0, cv);
        model_step(1, cv);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_both();
        chk("rst.state", 32'(st_a), 32'd0);
        chk("rst.lamps", 32'({hw_a, fm_a}), 32'({3'b001, 3'b100}));
        chk("rst.req",   32'(rq_a), 32'd0);
        chk("rst.tick",  32'(tk_a), 32'd0);
        @(negedge clk);
        c = 1'b0;
        check_both();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_phase(input phase_t p, input int idx_tbl);
        int idx;
        idx = 0;
        while (32'(st_a) == p.st && idx < 400) begin
            cyc(idx >= p.c_from && idx < p.c_to);
            idx++;
        end
        chk($sformatf("phase[%0d].st%0d_len", idx_tbl, p.st), 32'(idx), 32'(p.len));
    endtask

    phase_t tbl [18];

    initial begin
        int ticks;
        tbl = '{
            // single C pulse at cycle 2
            '{1, 0, 2, 3, 20}, '{0, 1, 0, 0, 12}, '{0, 2, 0, 0, 4},
            '{0, 3, 0, 0, 40}, '{0, 4, 0, 0, 12}, '{0, 5, 0, 0, 4},
            // C held high from reset; final HGRE relies on req latched in FYEL
            '{1, 0, 0, 999, 20}, '{0, 1, 0, 999, 12}, '{0, 2, 0, 999, 4},
            '{0, 3, 0, 999, 80}, '{0, 4, 0, 999, 12}, '{0, 5, 0, 999, 4},
            '{0, 0, 0, 0, 20},
            // C high entering FGRE, dropped at FGRE cycle 56
            '{0, 1, 0, 999, 12}, '{0, 2, 0, 999, 4}, '{0, 3, 0, 56, 60},
            '{0, 4, 0, 0, 12}, '{0, 5, 0, 0, 4}
        };

        model_reset();
        @(negedge clk);
        do_reset();

        // Idle: no request, highway green holds, tick every DIV cycles.
        ticks = 0;
        for (int i = 0; i < 200; i++) begin
            ticks += int'(tk_a);
            cyc(1'b0);
        end
        chk("idle.ticks", 32'(ticks), 32'(200 / DIV));
        chk("idle.state", 32'(st_a), 32'd0);

        for (int k = 0; k < 18; k++) begin
            if (tbl[k].rst_first != 0) begin
                if (k > 0) begin
                    chk("end_seq.state", 32'(st_a), 32'd0);
                    chk("end_seq.req",   32'(rq_a), 32'd0);
                end
                do_reset();
            end
            run_phase(tbl[k], k);
        end

        // Reset at FGRE cycle 10, then HGRE must again last exactly 20 cycles.
        begin
            int guard;
            guard = 0;
            cyc(1'b1);
            while (st_a != 3'd3 && guard < 200) begin
                cyc(1'b0);
                guard++;
            end
            chk("mid_rst.reach_fgre", 32'(st_a), 32'd3);
            for (int i = 0; i < 10; i++) cyc(1'b0);
            chk("mid_rst.pre_state", 32'(st_a), 32'd3);
            do_reset();
            run_phase('{0, 0, 0, 999, 20}, 99);
        end

        // Random sensor traffic with occasional resets, checked against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 699) == 0) do_reset();
            else cyc($urandom_range(0, 9) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
